mips_cpu_sequencer: RTL and testbench

MIPS_CPU_SEQUENCER -- requirements
Module: mips_cpu_sequencer

---
 rtl/mips_cpu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mips_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer: multi-cycle control sequencer for a MIPS-style CPU.
// It walks each instruction through fetch, decode and one or two execute
// cycles. Memory phases hold while waitrequest is high. MULT/MULTU/DIV/DIVU
// add a fixed wait of MULDIV_LATENCY cycles.
// Optional feature macro: SEQ_INSTR_COUNT_EN. When it is defined, the block
// counts retired instructions. When it is not defined, instr_count reads 0.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | HALTED      : idle after reset, or stopped after PC reached 0
//   1   | FETCH       : instruction read, held while memory stalls
//   2   | DECODE      : instruction register load
//   3   | EXEC1       : ALU / address phase, load or store access
//   4   | EXEC2       : load writeback or link-branch second cycle
//   5   | MULDIV_WAIT : fixed multiply/divide latency
//  6,7  | illegal     : recover to HALTED

module mips_cpu_sequencer #(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        pc_zero,
  input  logic [5:0]  opcode,
  input  logic [5:0]  fncode,
  input  logic [4:0]  regimm,
  output logic [2:0]  state,
  output logic        active,
  output logic        irwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        stall,
  output logic        muldiv_busy,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALTED      = 3'd0,
    S_FETCH       = 3'd1,
    S_DECODE      = 3'd2,
    S_EXEC1       = 3'd3,
    S_EXEC2       = 3'd4,
    S_MULDIV_WAIT = 3'd5
  } state_t;

  // The counter is loaded with latency-1 so that the 0 check ends the wait
  // after exactly MULDIV_LATENCY cycles.
  localparam logic [5:0] LAT_M1 = (MULDIV_LATENCY == 0) ? 6'd0 : 6'(MULDIV_LATENCY - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_started;
  logic       w_set_started;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_next;

  logic w_is_load;
  logic w_is_store;
  logic w_is_link;
  logic w_is_muldiv;

  assign w_is_load   = (opcode >= 6'h20) && (opcode <= 6'h26);
  assign w_is_store  = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
  assign w_is_link   = (opcode == 6'h01) && (regimm >= 5'd2);
  assign w_is_muldiv = (opcode == 6'h00) && (fncode >= 6'h18) && (fncode <= 6'h1B);

  // State, start flag and multiply/divide wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HALTED;
      r_started <= 1'b0;
      r_cnt     <= 6'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_set_started) r_started <= 1'b1;
    end
  end

  // Next-state, counter and memory/IR strobe decode.
  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_set_started = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    case (r_state)
      S_HALTED: begin
        // Start only once per reset. A halt through PC==0 is final.
        if (!r_started) begin
          w_next        = S_FETCH;
          w_set_started = 1'b1;
        end
      end
      S_FETCH: begin
        if (pc_zero) begin
          w_next = S_HALTED;
        end else begin
          memread = 1'b1;
          if (!waitrequest) w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        irwrite = 1'b1;
        w_next  = S_EXEC1;
      end
      S_EXEC1: begin
        if (w_is_load) begin
          memread = 1'b1;
          if (!waitrequest) w_next = S_EXEC2;
        end else if (w_is_store) begin
          memwrite = 1'b1;
          if (!waitrequest) w_next = S_FETCH;
        end else if (w_is_link) begin
          w_next = S_EXEC2;
        end else if (w_is_muldiv && (MULDIV_LATENCY != 0)) begin
          w_next     = S_MULDIV_WAIT;
          w_cnt_next = LAT_M1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_EXEC2: begin
        w_next = S_FETCH;
      end
      S_MULDIV_WAIT: begin
        if (r_cnt == 6'd0) w_next = S_FETCH;
        else w_cnt_next = r_cnt - 6'd1;
      end
      default: begin
        w_next = S_HALTED;
      end
    endcase
  end

  assign state       = r_state;
  assign active      = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC1) ||
                       (r_state == S_EXEC2) || (r_state == S_MULDIV_WAIT);
  assign muldiv_busy = (r_state == S_MULDIV_WAIT);
  assign stall       = (memread | memwrite) & waitrequest;

`ifdef SEQ_INSTR_COUNT_EN
  logic        w_retire;
  logic [31:0] r_instr_count;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_EXEC1) || (r_state == S_EXEC2) || (r_state == S_MULDIV_WAIT));

  // Retired-instruction counter. It wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_instr_count <= 32'h0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'h1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Testbench for mips_cpu_sequencer. It uses a vector table, hand-written
// corner sequences, and random instructions checked against a per-instruction
// cycle plan.
module tb_mips_cpu_sequencer;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic        waitrequest0 = 1'b0;
  logic        pc_zero = 1'b0;
  logic [5:0]  opcode = 6'h0, fncode = 6'h0;
  logic [5:0]  opcode0 = 6'h0, fncode0 = 6'h0;
  logic [4:0]  regimm = 5'h0;

  logic [2:0]  state, state0;
  logic        active, irwrite, memread, memwrite, stall, muldiv_busy;
  logic        active0, irwrite0, memread0, memwrite0, stall0, muldiv_busy0;
  logic [31:0] instr_count, instr_count0;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  mips_cpu_sequencer #(.MULDIV_LATENCY(LAT)) u4 (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc_zero(pc_zero),
    .opcode(opcode), .fncode(fncode), .regimm(regimm),
    .state(state), .active(active), .irwrite(irwrite), .memread(memread),
    .memwrite(memwrite), .stall(stall), .muldiv_busy(muldiv_busy),
    .instr_count(instr_count)
  );

  mips_cpu_sequencer #(.MULDIV_LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .waitrequest(waitrequest0), .pc_zero(pc_zero),
    .opcode(opcode0), .fncode(fncode0), .regimm(regimm),
    .state(state0), .active(active0), .irwrite(irwrite0), .memread(memread0),
    .memwrite(memwrite0), .stall(stall0), .muldiv_busy(muldiv_busy0),
    .instr_count(instr_count0)
  );

  typedef struct {
    logic [2:0] st;
    logic mr, mw, ir, busy, wr;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] ri;
    int         ns;
    logic       e_mr;
    logic       e_mw;
    logic [2:0] t_st;
    int         t_n;
  } vec_t;

  vec_t tbl[14];
  cyc_t plan[$];

  function automatic logic [31:0] exp_ic();
`ifdef SEQ_INSTR_COUNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input logic mr, input logic mw,
                              input logic ir, input logic busy, input logic wr);
    cyc_t c;
    c.st = st; c.mr = mr; c.mw = mw; c.ir = ir; c.busy = busy; c.wr = wr;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Starts at posedge+1. Drives one cycle, checks it at the negedge, and
  // returns at the next posedge+1.
  task automatic apply_cycle(input cyc_t c);
    waitrequest = c.wr;
    @(negedge clk);
    chk("state", 32'(state), 32'(c.st));
    chk("memread", 32'(memread), 32'(c.mr));
    chk("memwrite", 32'(memwrite), 32'(c.mw));
    chk("irwrite", 32'(irwrite), 32'(c.ir));
    chk("stall", 32'(stall), 32'((c.mr | c.mw) & c.wr));
    chk("muldiv_busy", 32'(muldiv_busy), 32'(c.busy));
    chk("active", 32'(active), 32'((c.st >= 3'd1) && (c.st <= 3'd5)));
    chk("instr_count", instr_count, exp_ic());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_strobes", 32'({irwrite, memread, memwrite, stall, muldiv_busy}), 32'd0);
    chk("rst_icount", instr_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0;
    apply_cycle(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Reference plan: the cycles one instruction takes, built from the
  // instruction class, and the stall counts chosen for fetch and data access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] ri,
                           input int nf, input int ne);
    bit is_load, is_store, is_link, is_md;
    is_load  = (op >= 6'd32) && (op <= 6'd38);
    is_store = (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
    is_link  = (op == 6'd1) && (ri >= 5'd2);
    is_md    = (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
    opcode = op; fncode = fn; regimm = ri;
    plan.delete();
    for (int k = 0; k < nf; k++) plan.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    plan.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    plan.push_back(mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1))));
    if (is_load || is_store) begin
      for (int k = 0; k < ne; k++)
        plan.push_back(mk(3'd3, 1'(is_load), 1'(is_store), 1'b0, 1'b0, 1'b1));
      plan.push_back(mk(3'd3, 1'(is_load), 1'(is_store), 1'b0, 1'b0, 1'b0));
      if (is_load) plan.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1))));
    end else begin
      plan.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1))));
      if (is_link) plan.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1))));
      if (is_md)
        for (int k = 0; k < LAT; k++)
          plan.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
    end
    foreach (plan[i]) apply_cycle(plan[i]);
    exp_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{6'h09, 6'h00, 5'd0,  0, 1'b0, 1'b0, 3'd0, 0};  // ADDIU
    tbl[1]  = '{6'h23, 6'h00, 5'd0,  3, 1'b1, 1'b0, 3'd4, 1};  // LW, 3 stalls
    tbl[2]  = '{6'h20, 6'h00, 5'd0,  0, 1'b1, 1'b0, 3'd4, 1};  // LB
    tbl[3]  = '{6'h26, 6'h00, 5'd0,  1, 1'b1, 1'b0, 3'd4, 1};  // LWR
    tbl[4]  = '{6'h2B, 6'h00, 5'd0,  0, 1'b0, 1'b1, 3'd0, 0};  // SW
    tbl[5]  = '{6'h28, 6'h00, 5'd0,  2, 1'b0, 1'b1, 3'd0, 0};  // SB, 2 stalls
    tbl[6]  = '{6'h01, 6'h00, 5'd17, 0, 1'b0, 1'b0, 3'd4, 1};  // BGEZAL
    tbl[7]  = '{6'h01, 6'h00, 5'd1,  1, 1'b0, 1'b0, 3'd0, 0};  // BGEZ, wr ignored
    tbl[8]  = '{6'h00, 6'h18, 5'd0,  0, 1'b0, 1'b0, 3'd5, 4};  // MULT
    tbl[9]  = '{6'h00, 6'h1B, 5'd0,  0, 1'b0, 1'b0, 3'd5, 4};  // DIVU
    tbl[10] = '{6'h00, 6'h21, 5'd0,  0, 1'b0, 1'b0, 3'd0, 0};  // ADDU
    tbl[11] = '{6'h3F, 6'h00, 5'd0,  0, 1'b0, 1'b0, 3'd0, 0};  // unimplemented
    tbl[12] = '{6'h27, 6'h00, 5'd0,  1, 1'b0, 1'b0, 3'd0, 0};  // not a load
    tbl[13] = '{6'h2A, 6'h00, 5'd0,  0, 1'b0, 1'b0, 3'd0, 0};  // not a store

    // Reset, then one ADDIU on u4 while u0 (zero latency) runs MULT.
    opcode0 = 6'h00; fncode0 = 6'h18; waitrequest0 = 1'b0;
    do_reset();
    opcode = 6'h09; fncode = 6'h00; regimm = 5'd0; waitrequest = 1'b0;
    @(negedge clk);
    chk("t1_fetch", 32'(state), 32'd1);
    chk("t1_fetch_mr", 32'(memread), 32'd1);
    chk("t1_fetch_ir", 32'(irwrite), 32'd0);
    chk("t1_u0_fetch", 32'(state0), 32'd1);
    chk("t1_u0_mr", 32'({memread0, active0}), 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_decode", 32'(state), 32'd2);
    chk("t1_decode_ir", 32'(irwrite), 32'd1);
    chk("t1_u0_decode", 32'({state0, irwrite0}), 32'({3'd2, 1'b1}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_exec1", 32'(state), 32'd3);
    chk("t1_exec1_ir", 32'(irwrite), 32'd0);
    chk("t1_u0_exec1", 32'(state0), 32'd3);
    chk("t1_u0_quiet", 32'({muldiv_busy0, memwrite0, stall0}), 32'd0);
    @(posedge clk); #1;
    exp_cnt++;
    chk("t1_back_fetch", 32'(state), 32'd1);
    chk("t1_icount", instr_count, exp_ic());
    chk("t1_u0_lat0_fetch", 32'(state0), 32'd1);
    chk("t1_u0_icount", instr_count0, exp_ic());
    @(posedge clk); #1;

    // Vector table. Each record starts in FETCH.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      int n1;
      opcode = tbl[i].op; fncode = tbl[i].fn; regimm = tbl[i].ri;
      waitrequest = 1'b0;
      @(negedge clk);
      chk("v_fetch", 32'(state), 32'd1);
      @(posedge clk); #1;
      waitrequest = 1'b1;
      @(negedge clk);
      chk("v_decode", 32'({state, irwrite, stall}), 32'({3'd2, 1'b1, 1'b0}));
      @(posedge clk); #1;
      n1 = (tbl[i].e_mr || tbl[i].e_mw) ? tbl[i].ns + 1 : 1;
      for (int k = 0; k < n1; k++) begin
        waitrequest = (k < tbl[i].ns);
        @(negedge clk);
        chk("v_exec1", 32'(state), 32'd3);
        chk("v_exec1_mr", 32'(memread), 32'(tbl[i].e_mr));
        chk("v_exec1_mw", 32'(memwrite), 32'(tbl[i].e_mw));
        chk("v_exec1_stall", 32'(stall), 32'((tbl[i].e_mr | tbl[i].e_mw) & waitrequest));
        @(posedge clk); #1;
      end
      for (int k = 0; k < tbl[i].t_n; k++) begin
        waitrequest = 1'b0;
        @(negedge clk);
        chk("v_tail", 32'(state), 32'(tbl[i].t_st));
        chk("v_tail_busy", 32'(muldiv_busy), 32'(tbl[i].t_st == 3'd5));
        chk("v_tail_mem", 32'({memread, memwrite}), 32'd0);
        @(posedge clk); #1;
      end
      exp_cnt++;
      chk("v_end_fetch", 32'(state), 32'd1);
      chk("v_icount", instr_count, exp_ic());
    end

    // Random instruction stream.
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      logic [4:0] ri;
      int sel;
      fn = 6'($urandom_range(0, 63));
      ri = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin op = 6'd0; fn = 6'(24 + $urandom_range(0, 3)); end
        1: op = 6'd0;
        2: op = 6'd1;
        3: op = 6'($urandom_range(32, 38));
        4: begin
          int s;
          s = $urandom_range(0, 2);
          op = (s == 0) ? 6'd40 : (s == 1) ? 6'd41 : 6'd43;
        end
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, ri, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset asserted in the second MULDIV_WAIT cycle aborts without retiring.
    do_reset();
    run_instr(6'h09, 6'h00, 5'd0, 0, 0);
    opcode = 6'h00; fncode = 6'h18;
    apply_cycle(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    apply_cycle(mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    apply_cycle(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    apply_cycle(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_icount", instr_count, 32'd0);
    chk("abort_busy", 32'({muldiv_busy, active}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0;
    apply_cycle(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("abort_restart", 32'(state), 32'd1);

    // PC==0 in FETCH with memory stalled, then a permanent halt.
    run_instr(6'h2B, 6'h00, 5'd0, 1, 0);
    pc_zero = 1'b1; waitrequest = 1'b1;
    @(negedge clk);
    chk("halt_fetch", 32'(state), 32'd1);
    chk("halt_mr", 32'({memread, stall}), 32'd0);
    chk("halt_active", 32'(active), 32'd1);
    @(posedge clk); #1;
    pc_zero = 1'b0;
    for (int k = 0; k < 11; k++)
      apply_cycle(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1))));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
